alu_cmd_sequencer: RTL
======================

# alu_cmd_sequencer

Command front end for the memory-mapped ALU. Accepts one operation (A, B, opcode) per valid/ready handshake, drives the memory write port to program the four ALU registers in order: A at 0, B at 1, OPERATION at 2, EXECUTE at 3. It then waits for the registered ALU result and returns it on a valid/ready response channel. It sits directly upstream of the memory/ALU block and is its only bus master.

## Interface
Parameters:
- ADDR_WIDTH, 2, memory address width.
- DATA_WIDTH, 8, operand and memory data width.
- RES_WIDTH, 16, ALU result width.
- SETTLE_CYCLES, 2, cycles waited after the EXECUTE write before sampling the result; legal minimum is 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_a  in  DATA_WIDTH  operand A.
- cmd_b  in  DATA_WIDTH  operand B.
- cmd_op  in  3  opcode: 0 zero, 1 add, 2 sub, 3 mul, 4 div; 5–7 illegal.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  RES_WIDTH  captured ALU result.
- rsp_div_zero  out  1  command was div with B==0.
- rsp_illegal  out  1  command had illegal opcode.
- mem_enable  out  1  memory access strobe.
- mem_rd_wr  out  1  1=read, 0=write; always 0 from this block.
- mem_addr  out  ADDR_WIDTH  register address.
- mem_wr_data  out  DATA_WIDTH  write data.
- mem_res_out  in  RES_WIDTH  registered ALU result from memory block.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, CLR_EXEC, WR_A, WR_B, WR_OP, SET_EXEC, SETTLE, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch a, b, op.
  - Legal op: go to CLR_EXEC.
  - Illegal op: go straight to RESP with rsp_result=0, rsp_illegal=1, and no memory writes.
- Each write state lasts exactly one cycle with mem_enable=1 and mem_rd_wr=0:
  - CLR_EXEC: addr 3, data 0. Freezes the ALU while its operands change.
  - WR_A: addr 0, data a.
  - WR_B: addr 1, data b.
  - WR_OP: addr 2, data {zero-pad, op}.
  - SET_EXEC: addr 3, data 1.
- SETTLE: lasts SETTLE_CYCLES cycles with mem_enable=0. On the edge ending the last SETTLE cycle, capture mem_res_out into rsp_result and enter RESP.
- rsp_div_zero = (op==4 && b==0), latched at acceptance. The result comes from the ALU, so it is 16'hDEAD in that case.
- RESP: rsp_valid=1, and all rsp_* outputs stay stable until rsp_ready. On rsp_valid&&rsp_ready, return to IDLE.
- Arithmetic is performed by the ALU at 16-bit width with zero-extended operands; the sequencer does not modify the result. Sub underflow wraps at 16 bits.

## Timing
- Reset values: cmd_ready=0 during reset and 1 in the first cycle after reset; rsp_valid=0; rsp_result=0; rsp_div_zero=0; rsp_illegal=0; mem_enable=0; mem_rd_wr=0; mem_addr=0; mem_wr_data=0; busy=0. State is IDLE.
- Command accepted at edge T:
  - Writes occupy cycles T+1..T+5.
  - SETTLE occupies T+6..T+5+SETTLE_CYCLES.
  - rsp_valid rises in cycle T+6+SETTLE_CYCLES, which is T+8 at the default.
- Illegal op: rsp_valid in cycle T+1.
- Throughput: one command in flight. cmd_ready=0 from acceptance until the cycle after the response handshake. The next acceptance is possible one cycle after the response handshake.
- Response backpressure: hold RESP indefinitely; no memory activity during RESP.
- Reset mid-operation: return to IDLE immediately and drop any partial write sequence. The memory block shares rst and reinitialises itself.
- A command presented while busy is not accepted; the upstream holds it.

## Structure
- Package alu_seq_pkg:
  - opcode enum OP_ZERO..OP_DIV.
  - Register address constants ADDR_A=0, ADDR_B=1, ADDR_OP=2, ADDR_EXEC=3.
  - DIV_ZERO_CODE=16'hDEAD.
  - State enum.
- Single module. The settle counter is a small inline counter (ceil(log2(SETTLE_CYCLES+1)) bits), so no sub-module is needed.

## Test plan
- add a=5, b=3 -> rsp_result=0x0008 exactly 8 cycles after acceptance. Write trace on the memory port is (3,00),(0,05),(1,03),(2,01),(3,01).
- mul a=0xFF, b=0xFF -> 0xFE01. sub a=3, b=5 -> 0xFFFE.
- div a=7, b=0 -> rsp_result=0xDEAD, rsp_div_zero=1. div a=200, b=7 -> 0x001C, rsp_div_zero=0.
- op=6 -> rsp_valid in cycle T+1, rsp_illegal=1, rsp_result=0, and mem_enable never asserted.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, no memory writes. Then release; a back-to-back second command (add 1,1 -> 0x0002) is accepted one cycle after the response handshake.
- Assert rst during WR_B -> next cycle state IDLE, all outputs at reset values. A following add 2,2 -> 0x0004.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : alu_seq_pkg
//  Description: Shared types and register map for the ALU command sequencer.
//  Revision   : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ZERO = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_MUL  = 3'd3,
      OP_DIV  = 3'd4
   } op_e;

   localparam int ADDR_A    = 0;
   localparam int ADDR_B    = 1;
   localparam int ADDR_OP   = 2;
   localparam int ADDR_EXEC = 3;

   localparam logic [15:0] DIV_ZERO_CODE = 16'hDEAD;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CLR_EXEC = 3'd1,
      S_WR_A     = 3'd2,
      S_WR_B     = 3'd3,
      S_WR_OP    = 3'd4,
      S_SET_EXEC = 3'd5,
      S_SETTLE   = 3'd6,
      S_RESP     = 3'd7
   } state_e;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= OP_DIV);
   endfunction

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module     : alu_cmd_sequencer
//  Description: Programs the memory-mapped ALU one command at a time and
//               returns its result over a valid/ready response channel.
//  Revision   : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int ADDR_WIDTH    = 2,
   parameter int DATA_WIDTH    = 8,
   parameter int RES_WIDTH     = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [DATA_WIDTH-1:0] cmd_a,
   input  logic [DATA_WIDTH-1:0] cmd_b,
   input  logic [2:0]            cmd_op,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [RES_WIDTH-1:0]  rsp_result,
   output logic                  rsp_div_zero,
   output logic                  rsp_illegal,
   output logic                  mem_enable,
   output logic                  mem_rd_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [RES_WIDTH-1:0]  mem_res_out,
   output logic                  busy
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e                state_q,  state_d;
   logic [CNT_W-1:0]      cnt_q,    cnt_d;
   logic [DATA_WIDTH-1:0] a_q,      a_d;
   logic [DATA_WIDTH-1:0] b_q,      b_d;
   logic [2:0]            op_q,     op_d;
   logic [RES_WIDTH-1:0]  result_q, result_d;
   logic                  dz_q,     dz_d;
   logic                  il_q,     il_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         dz_q     <= 1'b0;
         il_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         dz_q     <= dz_d;
         il_q     <= il_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      result_d    = result_q;
      dz_d        = dz_q;
      il_d        = il_q;
      mem_enable  = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               a_d      = cmd_a;
               b_d      = cmd_b;
               op_d     = cmd_op;
               result_d = '0;
               dz_d     = (cmd_op == OP_DIV) && (cmd_b == '0);
               il_d     = !is_legal_op(cmd_op);
               // Illegal opcodes never touch the ALU registers.
               state_d  = is_legal_op(cmd_op) ? S_CLR_EXEC : S_RESP;
            end
         end
         S_CLR_EXEC: begin
            mem_enable  = 1'b1;
            mem_addr    = ADDR_WIDTH'(ADDR_EXEC);
            mem_wr_data = '0;
            state_d     = S_WR_A;
         end
         S_WR_A: begin
            mem_enable  = 1'b1;
            mem_addr    = ADDR_WIDTH'(ADDR_A);
            mem_wr_data = a_q;
            state_d     = S_WR_B;
         end
         S_WR_B: begin
            mem_enable  = 1'b1;
            mem_addr    = ADDR_WIDTH'(ADDR_B);
            mem_wr_data = b_q;
            state_d     = S_WR_OP;
         end
         S_WR_OP: begin
            mem_enable  = 1'b1;
            mem_addr    = ADDR_WIDTH'(ADDR_OP);
            mem_wr_data = DATA_WIDTH'(op_q);
            state_d     = S_SET_EXEC;
         end
         S_SET_EXEC: begin
            mem_enable  = 1'b1;
            mem_addr    = ADDR_WIDTH'(ADDR_EXEC);
            mem_wr_data = DATA_WIDTH'(1);
            cnt_d       = '0;
            state_d     = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               result_d = mem_res_out;
               state_d  = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Ready is gated by rst so it reads low throughout the reset window.
   assign cmd_ready    = (state_q == S_IDLE) && !rst;
   assign rsp_valid    = (state_q == S_RESP);
   assign rsp_result   = result_q;
   assign rsp_div_zero = dz_q;
   assign rsp_illegal  = il_q;
   assign mem_rd_wr    = 1'b0;
   assign busy         = (state_q != S_IDLE);

endmodule : alu_cmd_sequencer
`default_nettype wire
